dualmem_widen_param: RTL and testbench



---
 rtl/dualmem_pkg.sv | 18 +
 rtl/dualmem_bytewe_core.sv | 42 ++++
 rtl/dualmem_widen_param.sv | 165 ++++++++++++++++
 tb/tb_dualmem_widen_param.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dualmem_pkg.sv
// dualmem_pkg: shared types and helpers for the
// asymmetric dual-port RAM.
package dualmem_pkg;

  typedef enum logic [1:0] {
    RESET,
    CLEAR,
    READY
  } clr_state_t;

  function automatic int unsigned lane_of(
    input int unsigned addr,
    input int unsigned ratio
  );
    return addr % ratio;
  endfunction

endpackage

// File: rtl/dualmem_bytewe_core.sv
// dualmem_bytewe_core: two-port byte-enable RAM,
// read-first, one-cycle registered read per port.
module dualmem_bytewe_core #(
  parameter int W = 64,
  parameter int DEPTH = 2048,
  localparam int BB = W / 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rea,
  input  logic [BB-1:0] wea,
  input  logic [AW-1:0] addra,
  input  logic [W-1:0]  dina,
  output logic [W-1:0]  qa,
  input  logic          reb,
  input  logic [BB-1:0] web,
  input  logic [AW-1:0] addrb,
  input  logic [W-1:0]  dinb,
  output logic [W-1:0]  qb
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BB; i++) begin
      if (wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
      if (web[i]) mem[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qa <= '0;
      qb <= '0;
    end else begin
      if (rea) qa <= mem[addra];
      if (reb) qb <= mem[addrb];
    end
  end

endmodule

// File: rtl/dualmem_widen_param.sv
// dualmem_widen_param: narrow/wide asymmetric RAM with
// post-reset zero clear and write-collision counting.
module dualmem_widen_param
  import dualmem_pkg::*;
#(
  parameter int NARROW_W = 16,
  parameter int RATIO = 4,
  parameter int DEPTH_B = 2048,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int WIDE_W = NARROW_W * RATIO,
  localparam int AB_W = $clog2(DEPTH_B),
  localparam int LW = $clog2(RATIO),
  localparam int AA_W = AB_W + LW,
  localparam int BA = NARROW_W / 8,
  localparam int BB = WIDE_W / 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ena,
  input  logic [BA-1:0]       wea,
  input  logic [AA_W-1:0]     addra,
  input  logic [NARROW_W-1:0] dina,
  output logic [NARROW_W-1:0] douta,
  output logic                valida,
  input  logic                enb,
  input  logic [BB-1:0]       web,
  input  logic [AB_W-1:0]     addrb,
  input  logic [WIDE_W-1:0]   dinb,
  output logic [WIDE_W-1:0]   doutb,
  output logic                validb,
  output logic                busy,
  output logic                collision,
  output logic [15:0]         coll_count
);

  clr_state_t          state;
  logic [AB_W-1:0]     ptr;
  logic                a_req, b_req;
  logic                a_wr, a_rd, b_rd, coll;
  logic [LW-1:0]       a_lane, lane1;
  logic [AB_W-1:0]     a_word, core_addrb;
  logic [BB-1:0]       wea_wide, web_req;
  logic [BB-1:0]       coll_mask, core_wea, core_web;
  logic [WIDE_W-1:0]   core_dinb, qa, qb;
  logic                va1, vb1;
  logic [NARROW_W-1:0] da1;

  assign a_req = ena & ~busy;
  assign b_req = enb & ~busy;
  assign a_wr = a_req & (|wea);
  assign a_rd = a_req & ~(|wea);
  assign b_rd = b_req & ~(|web);
  assign a_lane = LW'(lane_of(32'(addra), RATIO));
  assign a_word = addra[AA_W-1:LW];

  assign wea_wide = a_wr ?
    (BB'(wea) << (a_lane * BA)) : '0;
  assign web_req = b_req ? web : '0;

  // Port B owns any byte both ports write.
  assign coll_mask = (a_word == addrb) ?
    (wea_wide & web_req) : '0;
  assign coll = |coll_mask;
  assign core_wea = wea_wide & ~coll_mask;

  assign core_web = (state == CLEAR) ? '1 : web_req;
  assign core_addrb = (state == CLEAR) ? ptr : addrb;
  assign core_dinb = (state == CLEAR) ? '0 : dinb;

  dualmem_bytewe_core #(
    .W     (WIDE_W),
    .DEPTH (DEPTH_B)
  ) u_core (
    .clk   (clk),
    .rstn  (rstn),
    .rea   (a_rd),
    .wea   (core_wea),
    .addra (a_word),
    .dina  ({RATIO{dina}}),
    .qa    (qa),
    .reb   (b_rd),
    .web   (core_web),
    .addrb (core_addrb),
    .dinb  (core_dinb),
    .qb    (qb)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RESET;
      ptr <= '0;
      busy <= (CLEAR_ON_RESET != 0);
    end else begin
      unique case (state)
        RESET: begin
          if (CLEAR_ON_RESET != 0) begin
            state <= CLEAR;
            busy <= 1'b1;
          end else begin
            state <= READY;
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == AB_W'(DEPTH_B - 1)) begin
            state <= READY;
            busy <= 1'b0;
          end
        end
        READY: state <= READY;
        default: state <= RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      collision <= 1'b0;
      coll_count <= '0;
    end else begin
      collision <= coll;
      if (coll && coll_count != 16'hFFFF)
        coll_count <= coll_count + 1'b1;
    end
  end

  // Lane travels with its own read so a later addra cannot disturb it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      va1 <= 1'b0;
      vb1 <= 1'b0;
      lane1 <= '0;
    end else begin
      va1 <= a_rd;
      vb1 <= b_rd;
      if (a_rd) lane1 <= a_lane;
    end
  end

  assign da1 = qa[lane1*NARROW_W +: NARROW_W];

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valida <= 1'b0;
        validb <= 1'b0;
        douta <= '0;
        doutb <= '0;
      end else begin
        valida <= va1;
        validb <= vb1;
        if (va1) douta <= da1;
        if (vb1) doutb <= qb;
      end
    end
  end else begin : g_direct
    assign valida = va1;
    assign validb = vb1;
    assign douta = da1;
    assign doutb = qb;
  end

endmodule

// File: tb/tb_dualmem_widen_param.sv
// tb_dualmem_widen_param: directed and randomized checks
// against a byte-array reference model.
module tb_dualmem_widen_param;
  import dualmem_pkg::*;

  localparam int NW = 16;
  localparam int R = 4;
  localparam int DB = 2048;
  localparam int OREG = 0;
  localparam int WW = NW * R;
  localparam int ABW = $clog2(DB);
  localparam int AAW = ABW + $clog2(R);
  localparam int BA = NW / 8;
  localparam int BB = WW / 8;
  localparam int LAT = 1 + OREG;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          ena, enb;
  logic [BA-1:0] wea;
  logic [AAW-1:0] addra;
  logic [NW-1:0] dina, douta;
  logic          valida, validb;
  logic [BB-1:0] web;
  logic [ABW-1:0] addrb;
  logic [WW-1:0] dinb, doutb;
  logic          busy, collision;
  logic [15:0]   coll_count;

  always #5 clk = ~clk;

  dualmem_widen_param #(
    .NARROW_W       (NW),
    .RATIO          (R),
    .DEPTH_B        (DB),
    .OUT_REG        (OREG),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ena        (ena),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .douta      (douta),
    .valida     (valida),
    .enb        (enb),
    .web        (web),
    .addrb      (addrb),
    .dinb       (dinb),
    .doutb      (doutb),
    .validb     (validb),
    .busy       (busy),
    .collision  (collision),
    .coll_count (coll_count)
  );

  typedef struct {
    logic          va;
    logic [NW-1:0] da;
    logic          vb;
    logic [WW-1:0] db;
    logic          coll;
  } exp_t;

  int passed = 0;
  int total = 0;
  logic [7:0] mdl [DB*BB];
  int coll_cnt = 0;
  exp_t e;

  localparam logic [99:0] RST_V =
    {16'h0, 64'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1};

  task automatic idle();
    ena = 0; wea = '0; addra = '0; dina = '0;
    enb = 0; web = '0; addrb = '0; dinb = '0;
  endtask

  task automatic mdl_zero();
    for (int i = 0; i < DB * BB; i++) mdl[i] = 8'h00;
    coll_cnt = 0;
  endtask

  // Byte-level reference: reads see pre-write data, B wins shared bytes.
  task automatic model_step();
    int wa, wb, ln, k;
    e = '{va: 0, da: '0, vb: 0, db: '0, coll: 0};
    wa = int'(addra) / R;
    ln = int'(lane_of(int'(addra), R));
    wb = int'(addrb);
    if (ena && wea == 0) begin
      e.va = 1;
      for (int i = 0; i < BA; i++)
        e.da[i*8 +: 8] = mdl[wa*BB + ln*BA + i];
    end
    if (enb && web == 0) begin
      e.vb = 1;
      for (int i = 0; i < BB; i++)
        e.db[i*8 +: 8] = mdl[wb*BB + i];
    end
    if (ena)
      for (int i = 0; i < BA; i++)
        if (wea[i]) begin
          k = ln * BA + i;
          if (enb && wa == wb && web[k]) e.coll = 1;
          else mdl[wa*BB + k] = dina[i*8 +: 8];
        end
    if (enb)
      for (int i = 0; i < BB; i++)
        if (web[i]) mdl[wb*BB + i] = dinb[i*8 +: 8];
    if (e.coll && coll_cnt < 65535) coll_cnt++;
  endtask

  task automatic wait_lat();
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [99:0] got;
    idle();
    mdl_zero();
    #3 rstn = 0;
    #1;
    got = {douta, doutb, valida, validb, collision, coll_count, busy};
    total++;
    if (got !== RST_V)
      $display("FAIL reset_values got %h want %h", got, RST_V);
    else passed++;
  endtask

  task automatic test_clear();
    int n = 0;
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    while (n < 3 * DB) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    total++;
    if (n !== DB)
      $display("FAIL clear_cycles got %0d want %0d", n, DB);
    else passed++;
    enb = 1; addrb = ABW'(DB - 1);
    model_step();
    wait_lat();
    total++;
    if ({validb, doutb} !== {1'b1, 64'h0})
      $display("FAIL clear_read_last got %b %h want 1 0",
               validb, doutb);
    else passed++;
  endtask

  task automatic test_narrow_wide();
    ena = 1; wea = 2'b11; addra = 5; dina = 16'h1234;
    model_step();
    wait_lat();
    total++;
    if (valida !== 1'b0)
      $display("FAIL write_no_valida got %b want 0", valida);
    else passed++;
    enb = 1; addrb = 1;
    model_step();
    wait_lat();
    total++;
    if ({validb, doutb} !== {1'b1, 64'h0000_0000_1234_0000})
      $display("FAIL narrow_wide got %b %h want 1 0000000012340000",
               validb, doutb);
    else passed++;
  endtask

  task automatic test_wide_narrow();
    logic [NW-1:0] want [4];
    want = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    enb = 1; web = '1; addrb = 0;
    dinb = 64'hDDDD_CCCC_BBBB_AAAA;
    model_step();
    for (int i = 0; i <= 3 + LAT; i++) begin
      @(negedge clk);
      idle();
      if (i >= LAT) begin
        total++;
        if ({valida, douta} !== {1'b1, want[i-LAT]})
          $display("FAIL wide_narrow_%0d got %b %h want 1 %h",
                   i - LAT, valida, douta, want[i-LAT]);
        else passed++;
      end
      if (i < 4) begin
        ena = 1; addra = AAW'(i);
        model_step();
      end
    end
    @(negedge clk);
    total++;
    if ({valida, douta} !== {1'b0, 16'hDDDD})
      $display("FAIL douta_hold got %b %h want 0 dddd",
               valida, douta);
    else passed++;
  endtask

  task automatic test_collision();
    ena = 1; wea = 2'b01; addra = 4; dina = 16'h5555;
    enb = 1; web = 8'h03; addrb = 1; dinb = '1;
    model_step();
    @(negedge clk);
    idle();
    total++;
    if ({collision, coll_count} !== {1'b1, 16'd1})
      $display("FAIL coll_pulse got %b %0d want 1 1",
               collision, coll_count);
    else passed++;
    @(negedge clk);
    total++;
    if (collision !== 1'b0)
      $display("FAIL coll_single got %b want 0", collision);
    else passed++;
    enb = 1; addrb = 1;
    model_step();
    wait_lat();
    total++;
    if (doutb[7:0] !== 8'hFF || doutb !== e.db)
      $display("FAIL coll_data got %h want %h (byte0 ff)",
               doutb, e.db);
    else passed++;
    ena = 1; wea = 2'b01; addra = 4; dina = 16'h5555;
    enb = 1; web = 8'h02; addrb = 1; dinb = '1;
    model_step();
    @(negedge clk);
    idle();
    total++;
    if ({collision, coll_count} !== {1'b0, 16'd1})
      $display("FAIL nocoll_pulse got %b %0d want 0 1",
               collision, coll_count);
    else passed++;
    enb = 1; addrb = 1;
    model_step();
    wait_lat();
    total++;
    if (doutb[7:0] !== 8'h55 || doutb !== e.db)
      $display("FAIL nocoll_data got %h want %h (byte0 55)",
               doutb, e.db);
    else passed++;
  endtask

  task automatic test_read_first();
    logic [NW-1:0] d;
    d = NW'($urandom_range(1, 65535));
    enb = 1; addrb = 2;
    ena = 1; wea = 2'b11; addra = 8; dina = d;
    model_step();
    wait_lat();
    total++;
    if ({validb, doutb} !== {1'b1, 64'h0})
      $display("FAIL read_first_old got %b %h want 1 0",
               validb, doutb);
    else passed++;
    enb = 1; addrb = 2;
    model_step();
    wait_lat();
    total++;
    if ({validb, doutb} !== {1'b1, 48'h0, d})
      $display("FAIL read_first_new got %b %h want 1 %h",
               validb, doutb, d);
    else passed++;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t h;
    logic pc = 1'b0;
    for (int c = 0; c < 300 + LAT; c++) begin
      @(negedge clk);
      if (q.size() == LAT) begin
        h = q.pop_front();
        total++;
        if (valida !== h.va || (h.va && douta !== h.da))
          $display("FAIL rnd_a c%0d got %b %h want %b %h",
                   c, valida, douta, h.va, h.da);
        else passed++;
        total++;
        if (validb !== h.vb || (h.vb && doutb !== h.db))
          $display("FAIL rnd_b c%0d got %b %h want %b %h",
                   c, validb, doutb, h.vb, h.db);
        else passed++;
      end
      total++;
      if ({collision, coll_count} !== {pc, 16'(coll_cnt)})
        $display("FAIL rnd_coll c%0d got %b %0d want %b %0d",
                 c, collision, coll_count, pc, coll_cnt);
      else passed++;
      idle();
      if (c < 300) begin
        ena = 1'($urandom_range(0, 1));
        wea = ($urandom_range(0, 2) == 0) ? '0 : BA'($urandom);
        addra = AAW'($urandom_range(0, 15));
        dina = NW'($urandom);
        enb = 1'($urandom_range(0, 1));
        web = ($urandom_range(0, 2) == 0) ? '0 : BB'($urandom);
        addrb = ABW'($urandom_range(0, 3));
        dinb = WW'({$urandom, $urandom});
      end
      model_step();
      q.push_back(e);
      pc = e.coll;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_clear();
    logic [99:0] got;
    int n = 0;
    int stray = 0;
    @(posedge clk);
    #2 rstn = 0;
    #1;
    got = {douta, doutb, valida, validb, collision, coll_count, busy};
    total++;
    if (got !== RST_V)
      $display("FAIL async_reset got %h want %h", got, RST_V);
    else passed++;
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    repeat (100) @(posedge clk);
    #2 rstn = 0;
    #1;
    got = {douta, doutb, valida, validb, collision, coll_count, busy};
    total++;
    if (got !== RST_V)
      $display("FAIL midclear_reset got %h want %h", got, RST_V);
    else passed++;
    mdl_zero();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    while (n < 3 * DB) begin
      @(negedge clk);
      if (valida || validb) stray++;
      if (!busy) break;
      n++;
      ena = 1;
      wea = BA'($urandom_range(0, 3));
      addra = AAW'($urandom_range(0, 3));
      dina = NW'($urandom);
      enb = 1;
      web = BB'($urandom_range(0, 255));
      addrb = 0;
      dinb = '1;
    end
    idle();
    total++;
    if (n !== DB)
      $display("FAIL reclear_cycles got %0d want %0d", n, DB);
    else passed++;
    total++;
    if (stray !== 0)
      $display("FAIL busy_valids got %0d want 0", stray);
    else passed++;
    enb = 1; addrb = 0;
    model_step();
    wait_lat();
    total++;
    if ({validb, doutb} !== {1'b1, 64'h0})
      $display("FAIL busy_no_write got %b %h want 1 0",
               validb, doutb);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_narrow_wide();
    test_wide_narrow();
    test_collision();
    test_read_first();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
